// File: rtl/l2_flatten_pkg.sv
// Shared constants and state type for the layer-2 flatten stage.
// The conv engine uses the same memory-select codes.
package l2_flatten_pkg;

  localparam int unsigned DW      = 20;
  localparam int unsigned AW      = 12;
  localparam int unsigned L1_SIZE = 1024;
  localparam int unsigned IDX_W   = AW - 1;

  localparam logic [2:0] CSEL_K0 = 3'b011;
  localparam logic [2:0] CSEL_K1 = 3'b100;
  localparam logic [2:0] CSEL_L2 = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/l2_flatten.sv
// Layer-2 flatten: interleaves the two 32x32 layer-1 max-pool maps into the
// layer-2 memory as L2[2i]=K0[i], L2[2i+1]=K1[i]. Drives the shared bus only
// while busy; every output is registered.
module l2_flatten
  import l2_flatten_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    csel,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L1_SIZE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]    buf0;
  logic [DW-1:0]    buf1;

  // FSM, element counter and capture registers; outputs are set on the edge
  // entering each state so they are valid for that state's whole cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      buf0     <= '0;
      buf1     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      csel     <= '0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= RD0;
            busy     <= 1'b1;
            idx      <= '0;
            crd      <= 1'b1;
            csel     <= CSEL_K0;
            caddr_rd <= '0;
          end
        end
        RD0: begin
          buf0  <= cdata_rd;
          state <= RD1;
          csel  <= CSEL_K1;
        end
        RD1: begin
          buf1     <= cdata_rd;
          state    <= WR0;
          crd      <= 1'b0;
          cwr      <= 1'b1;
          csel     <= CSEL_L2;
          caddr_wr <= {idx, 1'b0};
          cdata_wr <= buf0;
        end
        WR0: begin
          state    <= WR1;
          caddr_wr <= {idx, 1'b1};
          cdata_wr <= buf1;
        end
        WR1: begin
          cwr <= 1'b0;
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            csel  <= '0;
          end else begin
            // caddr_rd is loaded with the incremented index directly so RD0
            // presents the next element in its first cycle.
            idx      <= idx + 1'b1;
            state    <= RD0;
            crd      <= 1'b1;
            csel     <= CSEL_K0;
            caddr_rd <= {1'b0, idx + 1'b1};
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          crd   <= 1'b0;
          cwr   <= 1'b0;
          csel  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_flatten.sv
// Bench for l2_flatten: memory models on the bus, a cycle-position model of
// the pass, and directed scenarios with literal expectations.
module tb_l2_flatten;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, crd, cwr;
  logic [2:0]  csel;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr;

  l2_flatten dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .csel(csel), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr)
  );

  always #5 clk = ~clk;

  logic [19:0] k0 [1024];
  logic [19:0] k1 [1024];
  logic [19:0] l2 [2048];

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int max_wr_addr = -1;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Layer-1 memories answer combinationally to the held read request.
  always_comb begin
    cdata_rd = '0;
    if (crd && csel == 3'b011) cdata_rd = k0[caddr_rd[9:0]];
    else if (crd && csel == 3'b100) cdata_rd = k1[caddr_rd[9:0]];
  end

  // Layer-2 memory plus write accounting.
  always @(posedge clk) begin
    if (cwr && csel == 3'b101) begin
      l2[caddr_wr[10:0]] <= cdata_wr;
      wr_cnt++;
      if (int'(caddr_wr) > max_wr_addr) max_wr_addr = int'(caddr_wr);
    end
  end

  // Model: position within a pass (0 = not in a pass, 1..4097 = cycle after accept).
  int m_c = 0;
  always @(posedge clk) begin
    if (!reset) m_c <= 0;
    else if (m_c == 0) m_c <= start ? 1 : 0;
    else if (m_c == 4097) m_c <= 0;
    else m_c <= m_c + 1;
  end

  int e_i, e_p;
  logic e_busy, e_done, e_crd, e_cwr;
  logic [2:0] e_csel;

  // Per-cycle comparison of the bus against the model.
  always @(negedge clk) begin
    if (chk_en && reset) begin
      e_i = (m_c - 1) / 4;
      e_p = (m_c - 1) % 4;
      e_busy = (m_c >= 1 && m_c <= 4096);
      e_done = (m_c == 4097);
      e_crd  = e_busy && (e_p == 0 || e_p == 1);
      e_cwr  = e_busy && (e_p == 2 || e_p == 3);
      e_csel = !e_busy ? 3'b000 : (e_p == 0) ? 3'b011 : (e_p == 1) ? 3'b100 : 3'b101;
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("crd", crd, e_crd);
      check("cwr", cwr, e_cwr);
      check("csel", csel, e_csel);
      if (e_crd) check("caddr_rd", caddr_rd, e_i);
      if (e_cwr) begin
        check("caddr_wr", caddr_wr, 2 * e_i + (e_p - 2));
        check("cdata_wr", cdata_wr, (e_p == 2) ? k0[e_i] : k1[e_i]);
      end
      check("crd_and_cwr", crd & cwr, 0);
      if (!busy) check("csel_idle", csel, 0);
      else check("csel_valid", (csel == 3'b011 || csel == 3'b100 || csel == 3'b101), 1);
      if (done) done_cnt++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_csel"}, csel, 0);
    check({tag, "_crd"}, crd, 0);
    check({tag, "_caddr_rd"}, caddr_rd, 0);
    check({tag, "_cwr"}, cwr, 0);
    check({tag, "_caddr_wr"}, caddr_wr, 0);
    check({tag, "_cdata_wr"}, cdata_wr, 0);
  endtask

  task automatic clear_l2();
    for (int a = 0; a < 2048; a++) l2[a] = 20'h5A5A5;
  endtask

  // One pass from a start pulse; n is the cycle (after the accept edge) in which done appears.
  task automatic run_pass(input int pulse_at, output int n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
      start = (pulse_at != 0 && n == pulse_at);
    end
    start = 1'b0;
    if (n >= 5000) check("done_timeout", done, 1);
  endtask

  task automatic verify_l2(input string tag);
    for (int i = 0; i < 1024; i++) begin
      check({tag, "_even"}, l2[2*i],   (i == 1023) ? 20'hFFFFF : 20'(i));
      check({tag, "_odd"},  l2[2*i+1], (i == 1023) ? 20'h00001 : (20'h80000 | 20'(i)));
    end
    check({tag, "_l2_0"},    l2[0],    20'h00000);
    check({tag, "_l2_1"},    l2[1],    20'h80000);
    check({tag, "_l2_7"},    l2[7],    20'h80003);
    check({tag, "_l2_2046"}, l2[2046], 20'hFFFFF);
    check({tag, "_l2_2047"}, l2[2047], 20'h00001);
  endtask

  int n, w;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      k0[i] = 20'(i);
      k1[i] = 20'h80000 | 20'(i);
    end
    k0[1023] = 20'hFFFFF;
    k1[1023] = 20'h00001;
    clear_l2();

    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Full pass with a stray start pulse at cycle 50.
    run_pass(50, n);
    check("done_cycle", n, 4097);
    repeat (20) @(negedge clk);
    check("wr_count", wr_cnt, 2048);
    check("max_wr_addr", max_wr_addr, 2047);
    verify_l2("pass1");

    // start held high: exactly one pass per done, immediate restart.
    done_cnt = 0;
    start = 1'b1;
    repeat (10000) @(negedge clk);
    check("held_done_cnt", done_cnt, 2);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("held_done_final", done_cnt, 3);
    repeat (5) @(negedge clk);

    // Reset at cycle 1000 of a pass, then a clean rerun.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (999) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("abort");
    reset = 1'b1;
    w = wr_cnt;
    repeat (50) @(negedge clk);
    check("no_wr_after_abort", wr_cnt, w);
    clear_l2();
    wr_cnt = 0;
    max_wr_addr = -1;
    run_pass(0, n);
    check("rerun_done_cycle", n, 4097);
    repeat (20) @(negedge clk);
    check("rerun_wr_count", wr_cnt, 2048);
    check("rerun_max_wr_addr", max_wr_addr, 2047);
    verify_l2("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
